// File: rtl/dpram_access_arbiter.sv
// Dual-port RAM access arbiter: independent round-robin arbitration for the write and read
// ports, registered RAM controls, one-hot tagged read return and read/write collision blocking.
module dpram_access_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned RAM_WIDTH = 64,
  parameter int unsigned ADDR_SIZE = 4,
  parameter int unsigned RD_LAT    = 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             wr_req,
  input  logic [NUM_REQ*ADDR_SIZE-1:0]   wr_addr,
  input  logic [NUM_REQ*RAM_WIDTH-1:0]   wr_data,
  output logic [NUM_REQ-1:0]             wr_gnt,
  input  logic [NUM_REQ-1:0]             rd_req,
  input  logic [NUM_REQ*ADDR_SIZE-1:0]   rd_addr,
  output logic [NUM_REQ-1:0]             rd_gnt,
  output logic [NUM_REQ-1:0]             rd_valid,
  output logic [RAM_WIDTH-1:0]           rd_data,
  output logic                           write,
  output logic [ADDR_SIZE-1:0]           wr_address,
  output logic [RAM_WIDTH-1:0]           data_in,
  output logic                           read,
  output logic [ADDR_SIZE-1:0]           rd_address,
  input  logic [RAM_WIDTH-1:0]           data_out
);

  localparam int unsigned PtrW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
  logic                 rd_blocked_q, rd_blocked_d;

  logic                 w_found, r_found;
  logic [PtrW-1:0]      w_idx, r_idx;
  logic [ADDR_SIZE-1:0] w_addr, r_addr;
  logic [RAM_WIDTH-1:0] w_data;
  logic                 collision;
  logic                 w_grant, r_grant;

  logic                 write_q;
  logic [ADDR_SIZE-1:0] wr_address_q;
  logic [RAM_WIDTH-1:0] data_in_q;
  logic                 read_q;
  logic [ADDR_SIZE-1:0] rd_address_q;
  logic [NUM_REQ-1:0]   tag_q [RD_LAT+1];
  logic [NUM_REQ-1:0]   rd_valid_q;
  logic [RAM_WIDTH-1:0] rd_data_q;

  // Returns {found, index} of the first active request at or after ptr, wrapping.
  function automatic logic [PtrW:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                            input logic [PtrW-1:0]    ptr);
    logic            found;
    logic [PtrW-1:0] idx;
    logic [PtrW-1:0] cand;
    int              j;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = int'(ptr) + i;
      if (j >= int'(NUM_REQ)) j = j - int'(NUM_REQ);
      cand = PtrW'(j);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    return {found, idx};
  endfunction

  function automatic logic [PtrW-1:0] ptr_next(input logic [PtrW-1:0] idx);
    if (idx == PtrW'(NUM_REQ - 1)) return '0;
    return idx + PtrW'(1);
  endfunction

  always_comb begin
    {w_found, w_idx} = rr_pick(wr_req, wr_ptr_q);
    {r_found, r_idx} = rr_pick(rd_req, rd_ptr_q);
  end

  assign w_addr = wr_addr[w_idx*ADDR_SIZE +: ADDR_SIZE];
  assign w_data = wr_data[w_idx*RAM_WIDTH +: RAM_WIDTH];
  assign r_addr = rd_addr[r_idx*ADDR_SIZE +: ADDR_SIZE];

  // Collisions alternate between the ports so neither side can be starved.
  assign collision = w_found && r_found && (w_addr == r_addr);
  assign w_grant   = w_found && !(collision && rd_blocked_q);
  assign r_grant   = r_found && !(collision && !rd_blocked_q);

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    rd_blocked_d = collision && !rd_blocked_q;
    if (w_grant) wr_ptr_d = ptr_next(w_idx);
    if (r_grant) rd_ptr_d = ptr_next(r_idx);
  end

  always_comb begin
    wr_gnt = '0;
    rd_gnt = '0;
    if (w_grant) wr_gnt[w_idx] = 1'b1;
    if (r_grant) rd_gnt[r_idx] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      rd_blocked_q <= 1'b0;
      write_q      <= 1'b0;
      wr_address_q <= '0;
      data_in_q    <= '0;
      read_q       <= 1'b0;
      rd_address_q <= '0;
      rd_valid_q   <= '0;
      rd_data_q    <= '0;
      for (int i = 0; i <= RD_LAT; i++) tag_q[i] <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      rd_blocked_q <= rd_blocked_d;
      write_q      <= w_grant;
      if (w_grant) begin
        wr_address_q <= w_addr;
        data_in_q    <= w_data;
      end
      read_q <= r_grant;
      if (r_grant) rd_address_q <= r_addr;
      // Stage 0 lines up with read; stage RD_LAT lines up with valid data_out.
      tag_q[0] <= rd_gnt;
      for (int i = 1; i <= RD_LAT; i++) tag_q[i] <= tag_q[i-1];
      rd_valid_q <= tag_q[RD_LAT];
      if (tag_q[RD_LAT] != '0) rd_data_q <= data_out;
    end
  end

  assign write      = write_q;
  assign wr_address = wr_address_q;
  assign data_in    = data_in_q;
  assign read       = read_q;
  assign rd_address = rd_address_q;
  assign rd_valid   = rd_valid_q;
  assign rd_data    = rd_data_q;

endmodule

// File: tb/tb_dpram_access_arbiter.sv
// Directed bench for dpram_access_arbiter with a one-cycle-latency behavioural dual-port RAM.
module tb_dpram_access_arbiter;
  localparam int N = 4;
  localparam int W = 64;
  localparam int A = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   wr_req, rd_req;
  logic [N*A-1:0] wr_addr, rd_addr;
  logic [N*W-1:0] wr_data;
  logic [N-1:0]   wr_gnt, rd_gnt, rd_valid;
  logic [W-1:0]   rd_data, data_in, data_out;
  logic           write, read;
  logic [A-1:0]   wr_address, rd_address;

  logic [W-1:0]   mem [16];
  int             n_cmp = 0;
  int             n_err = 0;

  always #5 clk = ~clk;

  dpram_access_arbiter #(.NUM_REQ(N), .RAM_WIDTH(W), .ADDR_SIZE(A), .RD_LAT(1)) dut (
    .clk(clk), .reset(reset),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .write(write), .wr_address(wr_address), .data_in(data_in),
    .read(read), .rd_address(rd_address), .data_out(data_out)
  );

  // RAM samples controls on the edge; data_out is valid one cycle after read is seen.
  always @(posedge clk) begin
    if (write) mem[wr_address] <= data_in;
    if (read) data_out <= mem[rd_address];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    wr_req = '0; rd_req = '0; wr_addr = '0; rd_addr = '0; wr_data = '0;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if ({write, read, rd_valid, wr_gnt, rd_gnt} !== '0) begin n_err++;
      $display("FAIL reset_ctrl got %b want 0", {write, read, rd_valid, wr_gnt, rd_gnt}); end
    n_cmp++; if ({wr_address, rd_address, data_in, rd_data} !== '0) begin n_err++;
      $display("FAIL reset_data got %h want 0", {wr_address, rd_address, data_in, rd_data}); end
    rd_addr[1*A +: A] = 4'd4; rd_req = 4'b0010; #1;
    n_cmp++; if (rd_gnt !== 4'b0010) begin n_err++;
      $display("FAIL rst_pre_gnt got %b want 0010", rd_gnt); end
    tick();
    rd_req = '0; reset = 1'b1; #1;
    n_cmp++; if ({read, rd_address, rd_valid} !== '0) begin n_err++;
      $display("FAIL rst_mid_read got %b want 0", {read, rd_address, rd_valid}); end
    tick();
    n_cmp++; if ({write, read, rd_valid, rd_data} !== '0) begin n_err++;
      $display("FAIL rst_held got %h want 0", {write, read, rd_valid, rd_data}); end
    tick();
    reset = 1'b0; #1;
    for (int k = 0; k < 3; k++) begin
      n_cmp++; if (rd_valid !== '0) begin n_err++;
        $display("FAIL rst_no_valid[%0d] got %b want 0000", k, rd_valid); end
      tick();
    end
    rd_req = 4'b1001; #1;
    n_cmp++; if (rd_gnt !== 4'b0001) begin n_err++;
      $display("FAIL rst_ptr got %b want 0001", rd_gnt); end
    tick();
    rd_req = '0;
    tick(); tick(); tick();
  endtask

  task automatic test_round_robin();
    logic [N-1:0] exp_gnt;
    do_reset();
    for (int i = 0; i < N; i++) begin
      wr_addr[i*A +: A] = A'(i + 8);
      wr_data[i*W +: W] = W'(64'h100 + i);
    end
    wr_req = 4'b1111; #1;
    for (int k = 0; k < 8; k++) begin
      exp_gnt = 4'b0001 << (k % 4);
      n_cmp++; if (wr_gnt !== exp_gnt) begin n_err++;
        $display("FAIL rr_gnt[%0d] got %b want %b", k, wr_gnt, exp_gnt); end
      tick();
      n_cmp++; if (write !== 1'b1 || wr_address !== A'((k % 4) + 8)) begin n_err++;
        $display("FAIL rr_write[%0d] got %b/%h want 1/%h", k, write, wr_address, (k % 4) + 8); end
      n_cmp++; if (data_in !== W'(64'h100 + (k % 4))) begin n_err++;
        $display("FAIL rr_data[%0d] got %h want %h", k, data_in, 64'h100 + (k % 4)); end
    end
    wr_req = '0;
    tick();
    n_cmp++; if (write !== 1'b0 || wr_address !== A'(11)) begin n_err++;
      $display("FAIL rr_idle got %b/%h want 0/b", write, wr_address); end
  endtask

  task automatic test_read_latency();
    do_reset();
    wr_addr[1*A +: A] = 4'd5; wr_data[1*W +: W] = 64'hDEAD_BEEF_0000_0005; wr_req = 4'b0010;
    tick();
    wr_req = '0;
    tick();
    rd_addr[2*A +: A] = 4'd5; rd_req = 4'b0100; #1;
    n_cmp++; if (rd_gnt !== 4'b0100) begin n_err++;
      $display("FAIL lat_gnt got %b want 0100", rd_gnt); end
    tick();
    rd_req = '0;
    n_cmp++; if (read !== 1'b1 || rd_address !== 4'd5 || rd_valid !== '0) begin n_err++;
      $display("FAIL lat_t1 got %b/%h/%b want 1/5/0000", read, rd_address, rd_valid); end
    tick();
    n_cmp++; if (read !== 1'b0 || rd_valid !== '0) begin n_err++;
      $display("FAIL lat_t2 got %b/%b want 0/0000", read, rd_valid); end
    tick();
    n_cmp++; if (rd_valid !== 4'b0100 || rd_data !== 64'hDEAD_BEEF_0000_0005) begin n_err++;
      $display("FAIL lat_t3 got %b/%h want 0100/deadbeef00000005", rd_valid, rd_data); end
    tick();
    n_cmp++; if (rd_valid !== '0) begin n_err++;
      $display("FAIL lat_t4 got %b want 0000", rd_valid); end
  endtask

  task automatic test_collision();
    do_reset();
    wr_addr[0*A +: A] = 4'd3; wr_data[0*W +: W] = 64'h55;
    rd_addr[1*A +: A] = 4'd3;
    wr_req = 4'b0001; rd_req = 4'b0010; #1;
    n_cmp++; if (wr_gnt !== 4'b0001 || rd_gnt !== 4'b0000) begin n_err++;
      $display("FAIL col_t0 got %b/%b want 0001/0000", wr_gnt, rd_gnt); end
    tick();
    n_cmp++; if (wr_gnt !== 4'b0000 || rd_gnt !== 4'b0010) begin n_err++;
      $display("FAIL col_t1 got %b/%b want 0000/0010", wr_gnt, rd_gnt); end
    n_cmp++; if (write !== 1'b1 || wr_address !== 4'd3) begin n_err++;
      $display("FAIL col_wr got %b/%h want 1/3", write, wr_address); end
    tick();
    wr_req = '0; rd_req = '0;
    n_cmp++; if (write !== 1'b0 || read !== 1'b1 || rd_address !== 4'd3) begin n_err++;
      $display("FAIL col_t2 got %b/%b/%h want 0/1/3", write, read, rd_address); end
    tick(); tick();
    n_cmp++; if (rd_valid !== 4'b0010 || rd_data !== 64'h55) begin n_err++;
      $display("FAIL col_data got %b/%h want 0010/55", rd_valid, rd_data); end
  endtask

  task automatic test_parallel();
    do_reset();
    wr_addr[0*A +: A] = 4'd2; wr_data[0*W +: W] = 64'hAA;
    rd_addr[1*A +: A] = 4'd7;
    wr_req = 4'b0001; rd_req = 4'b0010; #1;
    n_cmp++; if (wr_gnt !== 4'b0001 || rd_gnt !== 4'b0010) begin n_err++;
      $display("FAIL par_gnt got %b/%b want 0001/0010", wr_gnt, rd_gnt); end
    tick();
    wr_req = '0; rd_req = '0;
    n_cmp++; if (write !== 1'b1 || read !== 1'b1) begin n_err++;
      $display("FAIL par_ctrl got %b/%b want 1/1", write, read); end
    n_cmp++; if (wr_address !== 4'd2 || data_in !== 64'hAA || rd_address !== 4'd7) begin n_err++;
      $display("FAIL par_addr got %h/%h/%h want 2/aa/7", wr_address, data_in, rd_address); end
    tick();
  endtask

  task automatic test_write_then_read();
    do_reset();
    wr_addr[3*A +: A] = 4'd9; wr_data[3*W +: W] = 64'h1234; wr_req = 4'b1000; #1;
    n_cmp++; if (wr_gnt !== 4'b1000) begin n_err++;
      $display("FAIL wtr_wgnt got %b want 1000", wr_gnt); end
    tick();
    wr_req = '0; rd_addr[0*A +: A] = 4'd9; rd_req = 4'b0001; #1;
    n_cmp++; if (rd_gnt !== 4'b0001) begin n_err++;
      $display("FAIL wtr_rgnt got %b want 0001", rd_gnt); end
    tick();
    rd_req = '0;
    tick(); tick();
    n_cmp++; if (rd_valid !== 4'b0001 || rd_data !== 64'h1234) begin n_err++;
      $display("FAIL wtr_data got %b/%h want 0001/1234", rd_valid, rd_data); end
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] exp_tag;
    logic [W-1:0] exp_dat;
    do_reset();
    wr_addr[0*A +: A] = 4'd1; wr_data[0*W +: W] = 64'h11;
    wr_addr[1*A +: A] = 4'd2; wr_data[1*W +: W] = 64'h22;
    wr_req = 4'b0011;
    tick(); tick();
    wr_req = '0;
    tick();
    rd_addr[0*A +: A] = 4'd1; rd_addr[3*A +: A] = 4'd2;
    for (int c = 0; c < 8; c++) begin
      rd_req = (c < 4) ? 4'b1001 : 4'b0000; #1;
      if (c < 4) begin
        exp_tag = (c % 2 == 0) ? 4'b0001 : 4'b1000;
        n_cmp++; if (rd_gnt !== exp_tag) begin n_err++;
          $display("FAIL b2b_gnt[%0d] got %b want %b", c, rd_gnt, exp_tag); end
      end
      exp_tag = '0;
      exp_dat = rd_data;
      if (c >= 3 && c <= 6) begin
        exp_tag = (c % 2 == 1) ? 4'b0001 : 4'b1000;
        exp_dat = (c % 2 == 1) ? 64'h11 : 64'h22;
      end
      n_cmp++; if (rd_valid !== exp_tag || rd_data !== exp_dat) begin n_err++;
        $display("FAIL b2b_valid[%0d] got %b/%h want %b/%h", c, rd_valid, rd_data, exp_tag,
                 exp_dat); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_read_latency();
    test_collision();
    test_parallel();
    test_write_then_read();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
